// File: rtl/imem_loader_if.sv
// Byte-stream load bus between a program source and the instruction-memory loader.
// Carries the load request, the byte stream handshake, the memory write port
// and the status outputs (core reset, busy, done, error, checksum).
//   master : program source / system side (drives start, len_words, byte stream)
//   slave  : imem_loader (drives byte_ready, write port and status)
interface imem_loader_if;

    logic        start;
    logic [15:0] len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    modport master (
        output start,
        output len_words,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  cpu_rst_n,
        input  busy,
        input  done,
        input  error,
        input  checksum
    );

    modport slave (
        input  start,
        input  len_words,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output cpu_rst_n,
        output busy,
        output done,
        output error,
        output checksum
    );

endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a program as a little-endian byte stream,
// packs 4 bytes per word and writes the words to sequential word-aligned
// addresses starting at BASE_ADDR. Holds the core in reset while loading and
// keeps an XOR checksum of the words written in the current load.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : imem_loader_if.slave (start/len_words request, byte stream
//          valid/ready, write port wr_en/wr_addr/wr_data, cpu_rst_n,
//          busy, done, error, checksum)
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          BOOT_HOLD   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;

    // Low address bits forced to zero so writes are always word-aligned.
    localparam logic [ADDR_W-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_W-1:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_byte_idx;
    logic [LEN_W-1:0]    r_words_left;
    logic [DATA_W-1:0]   r_word;

    logic                r_byte_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_cpu_rst_n;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [DATA_W-1:0]   r_checksum;

    logic                w_xfer;
    logic                w_len_too_big;
    logic                w_len_zero;
    logic                w_last_byte;
    logic [DATA_W-1:0]   w_word_shifted;

    // byte_ready is only ever high in RECV, so this is the RECV transfer strobe.
    assign w_xfer         = bus.byte_valid & r_byte_ready;
    assign w_len_too_big  = 32'(bus.len_words) > 32'(DEPTH_WORDS);
    assign w_len_zero     = (bus.len_words == '0);
    assign w_last_byte    = (r_byte_idx == IDX_W'(3));
    // New byte enters at the top; after 4 shifts byte 0 sits in bits [7:0].
    assign w_word_shifted = {bus.byte_data, r_word[DATA_W-1:BYTE_W]};

    // Load sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_idx   <= '0;
            r_words_left <= '0;
            r_word       <= '0;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= BASE_ALIGNED;
            r_wr_data    <= '0;
            r_cpu_rst_n  <= ~BOOT_HOLD;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_checksum   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_len_too_big) begin
                            r_error <= 1'b1;
                        end else if (w_len_zero) begin
                            r_error <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_error      <= 1'b0;
                            r_checksum   <= '0;
                            r_wr_addr    <= BASE_ALIGNED;
                            r_byte_idx   <= '0;
                            r_words_left <= bus.len_words;
                            r_cpu_rst_n  <= 1'b0;
                            r_busy       <= 1'b1;
                            r_byte_ready <= 1'b1;
                            r_state      <= S_RECV;
                        end
                    end
                end

                S_RECV: begin
                    if (w_xfer) begin
                        r_word     <= w_word_shifted;
                        r_byte_idx <= r_byte_idx + IDX_W'(1);
                        if (w_last_byte) begin
                            // Word complete: present it on the write port next cycle.
                            r_wr_data    <= w_word_shifted;
                            r_wr_en      <= 1'b1;
                            r_byte_ready <= 1'b0;
                            r_state      <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    r_wr_en      <= 1'b0;
                    r_checksum   <= r_checksum ^ r_wr_data;
                    r_wr_addr    <= r_wr_addr + ADDR_W'(4);
                    r_words_left <= r_words_left - LEN_W'(1);
                    r_byte_idx   <= '0;
                    if (r_words_left == LEN_W'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_byte_ready <= 1'b1;
                        r_state      <= S_RECV;
                    end
                end

                S_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cpu_rst_n <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.cpu_rst_n  = r_cpu_rst_n;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives loads over the byte stream and checks the
// memory writes, checksum and status against a word-level model of the program.
module tb_imem_loader;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_loader_if u_if ();

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .BOOT_HOLD   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [7:0]  stim[$];

    // Write-port monitor: records every write; the stream must be stalled during a write.
    always @(negedge clk) begin
        if (rst === 1'b0 && u_if.wr_en === 1'b1) begin
            got_addr.push_back(u_if.wr_addr);
            got_data.push_back(u_if.wr_data);
            n_cmp++;
            if (u_if.byte_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ready_in_write: byte_ready=%b expected 0", u_if.byte_ready);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic fill_stim(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(negedge clk);
        u_if.start     = 1'b1;
        u_if.len_words = len;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid
    task automatic send_bytes(input string name, input int first, input int count, input int mode);
        int idx;
        int cyc;
        bit xfer;
        idx = first;
        cyc = 0;
        while (idx < first + count && cyc < 2000) begin
            @(negedge clk);
            if (mode == 1)      u_if.byte_valid = ((cyc % 2) == 0);
            else if (mode == 2) u_if.byte_valid = ($urandom_range(0, 2) != 0);
            else                u_if.byte_valid = 1'b1;
            u_if.byte_data = stim[idx];
            xfer = u_if.byte_valid && (u_if.byte_ready === 1'b1);
            @(posedge clk);
            #1;
            if (xfer) idx++;
            cyc++;
        end
        u_if.byte_valid = 1'b0;
        n_cmp++;
        if (idx != first + count) begin
            n_err++;
            $display("FAIL %s_stream: bytes accepted=%0d expected %0d", name, idx - first, count);
        end
    endtask

    // Waits for done, checks it is a single-cycle pulse and the post-load state,
    // then compares the recorded writes and checksum against the program model.
    task automatic finish_load(input string name, input int nwords);
        bit seen;
        logic [31:0] exp_w;
        logic [31:0] exp_sum;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (u_if.done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done_seen: done never asserted", name);
        end
        @(negedge clk);
        n_cmp++;
        if (u_if.done !== 1'b0 || u_if.busy !== 1'b0 || u_if.cpu_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL %s_post: done=%b busy=%b cpu_rst_n=%b expected 0 0 1",
                     name, u_if.done, u_if.busy, u_if.cpu_rst_n);
        end
        n_cmp++;
        if (got_data.size() != nwords) begin
            n_err++;
            $display("FAIL %s_wcount: writes=%0d expected %0d", name, got_data.size(), nwords);
        end
        exp_sum = 32'h0;
        for (int w = 0; w < nwords; w++) begin
            exp_w   = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
            exp_sum = exp_sum ^ exp_w;
            if (w < got_data.size()) begin
                n_cmp++;
                if (got_data[w] !== exp_w || got_addr[w] !== BASE + 32'(4 * w)) begin
                    n_err++;
                    $display("FAIL %s_word%0d: got %h@%h expected %h@%h",
                             name, w, got_data[w], got_addr[w], exp_w, BASE + 32'(4 * w));
                end
            end
        end
        n_cmp++;
        if (u_if.checksum !== exp_sum) begin
            n_err++;
            $display("FAIL %s_checksum: got %h expected %h", name, u_if.checksum, exp_sum);
        end
    endtask

    task automatic run_load(input string name, input int nwords, input int mode);
        got_addr.delete();
        got_data.delete();
        pulse_start(16'(nwords));
        n_cmp++;
        if (u_if.busy !== 1'b1 || u_if.cpu_rst_n !== 1'b0) begin
            n_err++;
            $display("FAIL %s_accept: busy=%b cpu_rst_n=%b expected 1 0",
                     name, u_if.busy, u_if.cpu_rst_n);
        end
        send_bytes(name, 0, 4 * nwords, mode);
        finish_load(name, nwords);
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        u_if.start      = 1'b0;
        u_if.len_words  = 16'h0;
        u_if.byte_valid = 1'b0;
        u_if.byte_data  = 8'h0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (u_if.byte_ready !== 1'b0 || u_if.wr_en !== 1'b0 || u_if.busy !== 1'b0 ||
            u_if.done !== 1'b0 || u_if.error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: ready=%b wr_en=%b busy=%b done=%b error=%b expected all 0",
                     u_if.byte_ready, u_if.wr_en, u_if.busy, u_if.done, u_if.error);
        end
        n_cmp++;
        if (u_if.wr_addr !== BASE || u_if.wr_data !== 32'h0 || u_if.checksum !== 32'h0) begin
            n_err++;
            $display("FAIL reset_regs: addr=%h data=%h sum=%h expected %h 0 0",
                     u_if.wr_addr, u_if.wr_data, u_if.checksum, BASE);
        end
        n_cmp++;
        if (u_if.cpu_rst_n !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cpu_rst_n: got %b expected 0", u_if.cpu_rst_n);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (u_if.cpu_rst_n !== 1'b0 || u_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL boot_hold: cpu_rst_n=%b busy=%b expected 0 0", u_if.cpu_rst_n, u_if.busy);
        end
    endtask

    task automatic load_basic_stim();
        stim.delete();
        stim.push_back(8'h78); stim.push_back(8'h56); stim.push_back(8'h34); stim.push_back(8'h12);
        stim.push_back(8'hEF); stim.push_back(8'hBE); stim.push_back(8'hAD); stim.push_back(8'hDE);
    endtask

    task automatic test_basic();
        load_basic_stim();
        run_load("basic", 2, 0);
        n_cmp++;
        if (u_if.checksum !== 32'hCC99E897) begin
            n_err++;
            $display("FAIL basic_sum_const: got %h expected cc99e897", u_if.checksum);
        end
    endtask

    task automatic test_toggle();
        load_basic_stim();
        run_load("toggle", 2, 1);
    endtask

    task automatic test_error();
        got_addr.delete();
        got_data.delete();
        pulse_start(16'(DEPTH + 1));
        n_cmp++;
        if (u_if.error !== 1'b1 || u_if.busy !== 1'b0 || u_if.byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL err_flag: error=%b busy=%b ready=%b expected 1 0 0",
                     u_if.error, u_if.busy, u_if.byte_ready);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (got_data.size() != 0 || u_if.error !== 1'b1) begin
            n_err++;
            $display("FAIL err_hold: writes=%0d error=%b expected 0 1", got_data.size(), u_if.error);
        end
        fill_stim(4);
        run_load("after_err", 1, 2);
        n_cmp++;
        if (u_if.error !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: error=%b expected 0", u_if.error);
        end
    endtask

    task automatic test_zero();
        got_addr.delete();
        got_data.delete();
        pulse_start(16'h0);
        @(negedge clk);
        n_cmp++;
        if (u_if.done !== 1'b1 || u_if.wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done: done=%b wr_en=%b expected 1 0", u_if.done, u_if.wr_en);
        end
        @(negedge clk);
        n_cmp++;
        if (u_if.done !== 1'b0 || u_if.cpu_rst_n !== 1'b1 || got_data.size() != 0) begin
            n_err++;
            $display("FAIL zero_post: done=%b cpu_rst_n=%b writes=%0d expected 0 1 0",
                     u_if.done, u_if.cpu_rst_n, got_data.size());
        end
    endtask

    task automatic test_reset_mid();
        fill_stim(12);
        got_addr.delete();
        got_data.delete();
        pulse_start(16'd3);
        send_bytes("rst_mid", 0, 6, 0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (u_if.busy !== 1'b0 || u_if.wr_addr !== BASE || u_if.cpu_rst_n !== 1'b0 ||
            u_if.byte_ready !== 1'b0 || u_if.wr_en !== 1'b0 || u_if.checksum !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_state: busy=%b addr=%h cpu_rst_n=%b ready=%b wr_en=%b sum=%h expected 0 %h 0 0 0 0",
                     u_if.busy, u_if.wr_addr, u_if.cpu_rst_n, u_if.byte_ready, u_if.wr_en,
                     u_if.checksum, BASE);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (got_data.size() != 1 || u_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_writes: writes=%0d busy=%b expected 1 0", got_data.size(), u_if.busy);
        end
        fill_stim(8);
        run_load("post_rst", 2, 2);
    endtask

    task automatic test_start_ignored();
        fill_stim(12);
        got_addr.delete();
        got_data.delete();
        pulse_start(16'd3);
        send_bytes("ign", 0, 5, 2);
        pulse_start(16'd9);
        send_bytes("ign", 5, 7, 2);
        finish_load("ign", 3);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (u_if.busy !== 1'b0 || got_data.size() != 3) begin
            n_err++;
            $display("FAIL ign_idle: busy=%b writes=%0d expected 0 3", u_if.busy, got_data.size());
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 5; it++) begin
            n = (it == 0) ? int'(DEPTH) : int'($urandom_range(1, DEPTH));
            fill_stim(4 * n);
            run_load("rand", n, 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_error();
        test_zero();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the fetch stage's instruction-memory read port.
- Receives a program as a byte stream over a valid/ready handshake and packs 4 little-endian bytes per word.
- Writes each word to the instruction memory write port at sequential word-aligned byte addresses.
- Holds the core in reset while loading and releases it on completion; also keeps a running XOR checksum of the loaded words.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.
- BOOT_HOLD, 1, 1: core is held in reset after loader reset until the first successful load; 0: core is released after loader reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- len_words  input  16  number of words to load; latched when start is accepted.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte, least significant byte of each word first.
- byte_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  32  byte address of the write, word-aligned.
- wr_data  output  32  assembled word.
- cpu_rst_n  output  1  active-low reset to the pipeline; 0 holds the core.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when a load completes.
- error  output  1  sticky flag for a rejected request.
- checksum  output  32  XOR of all words written in the current load.

Behaviour:
- Reset (asynchronous, any state, including mid-load):
  - state=IDLE; byte_ready, wr_en, busy, done, error = 0.
  - wr_addr=BASE_ADDR; wr_data=0; checksum=0.
  - cpu_rst_n = ~BOOT_HOLD.
  - A partially assembled word is discarded; memory contents are untouched.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 with len_words > DEPTH_WORDS: error<=1, stay IDLE, no writes, cpu_rst_n unchanged.
  - start=1 with len_words==0: error<=0, go to DONE; nothing is written.
  - start=1 otherwise: error<=0, checksum<=0, wr_addr<=BASE_ADDR, byte index<=0, words_left<=len_words, cpu_rst_n<=0, busy<=1, go to RECV.
- RECV:
  - byte_ready=1.
  - A byte is transferred when byte_valid and byte_ready are both 1.
  - Byte k (k=0..3) goes to bits [8k+7:8k] of the word being assembled.
  - Transfer of byte 3 goes to WRITE the next cycle.
  - No transfer: stay in RECV; no timeout.
- WRITE (exactly 1 cycle):
  - wr_en=1, byte_ready=0; wr_addr and wr_data are stable.
  - Next edge: checksum ^= wr_data, wr_addr += 4, words_left -= 1, byte index = 0.
  - Goes to DONE if words_left was 1, otherwise back to RECV.
- DONE (exactly 1 cycle):
  - done=1, busy<=0, cpu_rst_n<=1, then IDLE.
- start is ignored outside IDLE.
- A byte presented in WRITE/DONE/IDLE is not consumed; the source must hold it.
- Throughput: at most 4 bytes per 5 cycles; write latency is 1 cycle after byte 3 is accepted.
- wr_addr is 32-bit, computed as BASE_ADDR + 4*index, with no wrap inside a legal load (length is bounded by DEPTH_WORDS).
- checksum holds its final value after DONE until the next accepted start.

Test Plan:
- Reset, then start with len_words=2; stream bytes 78 56 34 12 EF BE AD DE.
  - Required: writes 0x12345678 @0x0 and 0xDEADBEEF @0x4.
  - Required: checksum=0xCC99E897, one-cycle done, cpu_rst_n 0->1 in the DONE cycle.
- Same load with byte_valid toggling every other cycle -> identical writes; no byte lost or duplicated; byte_ready=0 during WRITE.
- start with len_words=DEPTH_WORDS+1 -> error=1, no wr_en, busy=0.
  - Then start with len_words=1 -> error cleared and a normal single write.
- start with len_words=0 -> done pulse the cycle after start, no wr_en, cpu_rst_n=1.
- Assert rst after 2 bytes of word 1 in a 3-word load.
  - Required: immediate IDLE, wr_addr=BASE_ADDR, cpu_rst_n=~BOOT_HOLD, no spurious wr_en.
  - A fresh load afterwards starts at BASE_ADDR.
- start asserted during RECV -> ignored; len_words change mid-load has no effect on word count.
